// File: rtl/exec_sequencer_if.sv
// Sequencer <-> datapath/control-panel bundle: button, run switch, breakpoint,
// current instruction in; commit enable and status out.
interface exec_sequencer_if;
    logic        step_btn;
    logic        run_sw;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] cur_pc;
    logic [5:0]  op;
    logic        cpu_en;
    logic [1:0]  state;
    logic        halted;
    logic [15:0] instr_count;

    modport master (
        output step_btn, run_sw, bp_en, bp_addr, cur_pc, op,
        input  cpu_en, state, halted, instr_count
    );

    modport slave (
        input  step_btn, run_sw, bp_en, bp_addr, cur_pc, op,
        output cpu_en, state, halted, instr_count
    );
endinterface

// File: rtl/exec_sequencer.sv
// Single-step / free-run execution sequencer with debounced step button,
// PC breakpoint and halt opcode; cpu_en gates one instruction commit per cycle.
module exec_sequencer #(
    parameter int unsigned DB_CYCLES = 20,
    parameter logic [5:0]  HALT_OP   = 6'b111111
) (
    input logic             CLK,
    input logic             Reset,
    exec_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        STEP = 2'b01,
        RUN  = 2'b10,
        HALT = 2'b11
    } state_t;

    localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

    logic        sync_q1, sync_q2;
    logic        db_level, db_prev;
    logic [15:0] db_cnt;
    logic        step_req, halt_hit, bp_hit;
    state_t      st;
    logic        cpu_en_q, halted_q;
    logic [15:0] cnt_q;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= bus.step_btn;
            sync_q2 <= sync_q1;
        end
    end

    // Level flips on the DB_CYCLES-th consecutive differing sample.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            db_prev <= db_level;
            if (sync_q2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync_q2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
        end
    end

    assign step_req = db_level & ~db_prev;
    assign halt_hit = (bus.op == HALT_OP);
    assign bp_hit   = bus.bp_en && (bus.cur_pc == bus.bp_addr);

    // cur_pc is the instruction the datapath will commit if cpu_en is raised
    // at this edge, so stop conditions are judged on it before committing.
    // Entry from IDLE commits without a breakpoint check, which lets a run
    // resume past the breakpoint it stopped on.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            st       <= IDLE;
            cpu_en_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            cpu_en_q <= 1'b0;
            if (st != HALT && halt_hit) begin
                st       <= HALT;
                halted_q <= 1'b1;
            end else begin
                case (st)
                    IDLE: begin
                        if (bus.run_sw) begin
                            st       <= RUN;
                            cpu_en_q <= 1'b1;
                        end else if (step_req) begin
                            st       <= STEP;
                            cpu_en_q <= 1'b1;
                        end
                    end
                    STEP: st <= IDLE;
                    RUN: begin
                        if (!bus.run_sw || bp_hit) st <= IDLE;
                        else                       cpu_en_q <= 1'b1;
                    end
                    default: st <= HALT;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)        cnt_q <= '0;
        else if (cpu_en_q) cnt_q <= cnt_q + 16'd1;
    end

    assign bus.cpu_en      = cpu_en_q;
    assign bus.state       = st;
    assign bus.halted      = halted_q;
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed + randomized bench for exec_sequencer; a small datapath model
// advances cur_pc by 4 per commit and logs committed PCs.
module tb_exec_sequencer;
    localparam int DB = 4;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    exec_sequencer_if bus();

    exec_sequencer #(.DB_CYCLES(DB), .HALT_OP(6'h3F)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          exp_cnt;
    logic [31:0] halt_pc;
    logic [31:0] commit_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample after the edge, then let the datapath model react.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (bus.cpu_en) begin
            commit_q.push_back(bus.cur_pc);
            bus.cur_pc = bus.cur_pc + 32'd4;
        end
        bus.op = (bus.cur_pc == halt_pc) ? 6'h3F : 6'h00;
    endtask

    task automatic do_reset(input logic held);
        Reset        = 1'b0;
        bus.step_btn = held;
        bus.run_sw   = 1'b0;
        bus.bp_en    = 1'b0;
        bus.bp_addr  = 32'd0;
        bus.cur_pc   = 32'd0;
        bus.op       = 6'h00;
        halt_pc      = 32'hFFFF_FFFF;
        tick();
        tick();
        Reset = 1'b1;
        commit_q.delete();
        exp_cnt = 0;
    endtask

    initial begin
        int          first, n0, n1, nexp;
        logic [31:0] pc0, bpa;
        logic        stopped;

        // Reset state
        Reset = 1'b1;
        bus.step_btn = 1'b0; bus.run_sw = 1'b0; bus.bp_en = 1'b0;
        bus.bp_addr = 32'd0; bus.cur_pc = 32'd0; bus.op = 6'h00;
        halt_pc = 32'hFFFF_FFFF;
        #1 Reset = 1'b0;
        #1;
        chk("rst_state",  32'(bus.state), 32'd0);
        chk("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_count",  32'(bus.instr_count), 32'd0);

        // Button held through reset: one step, DB+3 edges to cpu_en
        do_reset(1'b1);
        first = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus.cpu_en && first < 0) first = k;
        end
        bus.step_btn = 1'b0;
        repeat (DB + 4) tick();
        exp_cnt = 1;
        chk("held_latency", 32'(first), 32'(DB + 3));
        chk("held_commits", 32'(commit_q.size()), 32'd1);
        chk("held_count",   32'(bus.instr_count), 32'(exp_cnt));
        chk("held_state",   32'(bus.state), 32'd0);

        // Bounce every 2 cycles: nothing commits
        for (int k = 0; k < 30; k++) begin
            if (k % 2 == 0) bus.step_btn = ~bus.step_btn;
            tick();
        end
        bus.step_btn = 1'b0;
        repeat (DB + 4) tick();
        chk("bounce2_count", 32'(bus.instr_count), 32'(exp_cnt));

        // Random bounce shorter than DB samples per run
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < 8; s++) begin
                bus.step_btn = ~bus.step_btn;
                repeat ($urandom_range(1, DB - 1)) tick();
            end
            bus.step_btn = 1'b0;
            repeat (DB + 4) tick();
            chk("rbounce_count", 32'(bus.instr_count), 32'(exp_cnt));
        end

        // Random-length clean presses: one commit each
        for (int r = 0; r < 4; r++) begin
            n0 = commit_q.size();
            bus.step_btn = 1'b1;
            repeat (DB + $urandom_range(0, 10)) tick();
            bus.step_btn = 1'b0;
            repeat (DB + 4) tick();
            exp_cnt++;
            chk("press_commits", 32'(commit_q.size() - n0), 32'd1);
            chk("press_count",   32'(bus.instr_count), 32'(exp_cnt));
        end

        // Breakpoint at 0x0C from PC 0
        do_reset(1'b0);
        bus.bp_en = 1'b1; bus.bp_addr = 32'h0C; bus.run_sw = 1'b1;
        stopped = 1'b0;
        for (int k = 0; k < 40 && !stopped; k++) begin
            tick();
            if (k > 0 && bus.state == 2'b00) stopped = 1'b1;
        end
        bus.run_sw = 1'b0;
        chk("bp_stopped", 32'(stopped), 32'd1);
        chk("bp_commits", 32'(commit_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk("bp_pc", commit_q[i], 32'(4 * i));
        chk("bp_cur_pc", bus.cur_pc, 32'h0C);
        chk("bp_count",  32'(bus.instr_count), 32'd3);
        // Single step commits the breakpoint instruction
        bus.step_btn = 1'b1;
        repeat (DB + 2) tick();
        bus.step_btn = 1'b0;
        repeat (DB + 4) tick();
        exp_cnt = 4;
        chk("bp_step_n",  32'(commit_q.size()), 32'd4);
        chk("bp_step_pc", commit_q[3], 32'h0C);
        chk("bp_step_count", 32'(bus.instr_count), 32'(exp_cnt));

        // Random breakpoints, each followed by a resume past it
        for (int r = 0; r < 4; r++) begin
            pc0  = bus.cur_pc;
            nexp = $urandom_range(1, 6);
            bpa  = pc0 + 32'(4 * nexp);
            bus.bp_addr = bpa;
            n0 = commit_q.size();
            bus.run_sw = 1'b1;
            stopped = 1'b0;
            for (int k = 0; k < 40 && !stopped; k++) begin
                tick();
                if (k > 0 && bus.state == 2'b00) stopped = 1'b1;
            end
            bus.run_sw = 1'b0;
            chk("rbp_stopped", 32'(stopped), 32'd1);
            chk("rbp_commits", 32'(commit_q.size() - n0), 32'(nexp));
            chk("rbp_first",   commit_q[n0], pc0);
            chk("rbp_last",    commit_q[commit_q.size() - 1], bpa - 32'd4);
            chk("rbp_cur_pc",  bus.cur_pc, bpa);
            n1 = commit_q.size();
            bus.run_sw = 1'b1;
            repeat (3) tick();
            bus.run_sw = 1'b0;
            repeat (2) tick();
            exp_cnt += nexp + 3;
            chk("resume_n",     32'(commit_q.size() - n1), 32'd3);
            chk("resume_first", commit_q[n1], bpa);
            chk("resume_pc",    bus.cur_pc, bpa + 32'd12);
            chk("resume_count", 32'(bus.instr_count), 32'(exp_cnt));
        end

        // Halt opcode at 0x10 during RUN
        do_reset(1'b0);
        halt_pc = 32'h10;
        bus.run_sw = 1'b1;
        stopped = 1'b0;
        for (int k = 0; k < 20 && !stopped; k++) begin
            tick();
            if (bus.halted) stopped = 1'b1;
        end
        chk("halt_seen",   32'(stopped), 32'd1);
        chk("halt_state",  32'(bus.state), 32'd3);
        chk("halt_cpu_en", 32'(bus.cpu_en), 32'd0);
        chk("halt_count",  32'(bus.instr_count), 32'd4);
        chk("halt_cur_pc", bus.cur_pc, 32'h10);
        bus.run_sw = 1'b0;
        bus.step_btn = 1'b1;
        repeat (DB + 6) tick();
        bus.step_btn = 1'b0;
        bus.run_sw = 1'b1;
        repeat (DB + 6) tick();
        bus.run_sw = 1'b0;
        chk("halt_hold_state", 32'(bus.state), 32'd3);
        chk("halt_hold_count", 32'(bus.instr_count), 32'd4);
        do_reset(1'b0);
        chk("halt_rst_state",  32'(bus.state), 32'd0);
        chk("halt_rst_halted", 32'(bus.halted), 32'd0);
        chk("halt_rst_count",  32'(bus.instr_count), 32'd0);

        // 65536 commits wrap the counter
        bus.run_sw = 1'b1;
        repeat (65536) tick();
        bus.run_sw = 1'b0;
        tick();
        chk("wrap_commits", 32'(commit_q.size()), 32'd65536);
        chk("wrap_count",   32'(bus.instr_count), 32'd0);
        chk("wrap_state",   32'(bus.state), 32'd0);

        // Asynchronous reset in the middle of a RUN cycle
        commit_q.delete();
        bus.run_sw = 1'b1;
        repeat (3) tick();
        chk("mid_cpu_en_pre", 32'(bus.cpu_en), 32'd1);
        chk("mid_count_pre",  32'(bus.instr_count), 32'd2);
        #2 Reset = 1'b0;
        #1;
        chk("mid_cpu_en", 32'(bus.cpu_en), 32'd0);
        chk("mid_state",  32'(bus.state), 32'd0);
        chk("mid_count",  32'(bus.instr_count), 32'd0);
        bus.run_sw = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        chk("post_rst_cpu_en", 32'(bus.cpu_en), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 20, the number of consecutive stable sampled cycles required to accept a step_btn level change (range 1..65535).
REQ-002 The block SHALL have parameter HALT_OP, default 6'b111111, the opcode that halts execution.
REQ-003 CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  reset, asynchronous, active-low.
REQ-005 step_btn  input  1  raw single-step pushbutton, asynchronous, bouncing.
REQ-006 run_sw  input  1  level: 1 = free-run requested.
REQ-007 bp_en  input  1  breakpoint enable.
REQ-008 bp_addr  input  32  breakpoint PC value.
REQ-009 cur_pc  input  32  PC of the instruction currently presented by the datapath.
REQ-010 op  input  6  opcode field of the current instruction.
REQ-011 cpu_en  output  1  datapath commit enable; gates PC, register file and data memory writes for one instruction.
REQ-012 state  output  2  FSM state: 00 IDLE, 01 STEP, 10 RUN, 11 HALT.
REQ-013 halted  output  1  high exactly when state = HALT.
REQ-014 instr_count  output  16  count of committed instructions.

Function
REQ-015 step_btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-016 The debounced level SHALL change only after the synchronized input differs from it for DB_CYCLES consecutive cycles; any sample equal to the debounced level SHALL clear the stability counter.
REQ-017 step_req SHALL be a 1-cycle pulse on each 0->1 transition of the debounced level; a held button SHALL produce exactly one pulse.
REQ-018 cpu_en SHALL be a registered output, high only in STEP, and in RUN when no stop condition holds.
REQ-019 halt_hit = (op == HALT_OP); bp_hit = bp_en && (cur_pc == bp_addr), full 32-bit compare.
REQ-020 Any state other than HALT with halt_hit SHALL go to HALT next cycle with cpu_en = 0; halt_hit has highest priority.
REQ-021 IDLE: run_sw = 1 -> RUN; else step_req -> STEP; else stay; cpu_en = 0.
REQ-022 IDLE: simultaneous run_sw = 1 and step_req SHALL go to RUN; the step_req is discarded.
REQ-023 STEP SHALL last exactly one cycle with cpu_en = 1, then return to IDLE; latency from step_req cycle n to cpu_en high is cycle n+1.
REQ-024 step_req arriving while in STEP or RUN SHALL be ignored, not queued.
REQ-025 RUN: cpu_en = 1 each cycle; run_sw = 0 -> IDLE with cpu_en = 0 from the next cycle.
REQ-026 RUN: bp_hit -> IDLE, and the instruction at bp_addr SHALL NOT commit, except in the first RUN cycle after entry from IDLE, where bp_hit is ignored so execution resumes past the breakpoint.
REQ-027 HALT SHALL be left only by Reset; cpu_en stays 0 and step_req and run_sw are ignored.
REQ-028 instr_count SHALL increment by 1 in each cycle cpu_en = 1 and wrap from 16'hFFFF to 16'h0000.

Reset
REQ-029 Reset low SHALL immediately force state = IDLE, cpu_en = 0, halted = 0, instr_count = 0, synchronizer flops = 0, debounced level = 0 and stability counter = 0.
REQ-030 Reset asserted mid-RUN or mid-STEP SHALL suppress cpu_en in the same cycle, with no partial commit.
REQ-031 After Reset deasserts, a button already held SHALL produce one step_req after DB_CYCLES + 2 cycles.

Verification
REQ-032 Step: DB_CYCLES = 4, op = 0, step_btn held high for 20 cycles -> exactly one cpu_en pulse, instr_count = 1, state back to 00.
REQ-033 Bounce: step_btn toggling every 2 cycles for 30 cycles, then low -> no cpu_en, instr_count = 0.
REQ-034 Breakpoint: bp_en = 1, bp_addr = 0x0000000C, cur_pc advancing by 4 per commit from 0, run_sw = 1 -> commits at PC 0, 4, 8, then state 00 with cur_pc = 0x0C and instr_count = 3; a following step_req commits 0x0C.
REQ-035 Resume: from the stopped state of REQ-034, toggle run_sw 0 -> 1 -> first RUN cycle commits 0x0C, run continues.
REQ-036 Halt: in RUN, op = 6'b111111 at PC 0x10 -> state 11, halted = 1, cpu_en = 0; step_req and run_sw ignored until Reset, then state 00 and instr_count = 0.
REQ-037 Wrap and async reset: preload by running 65536 commits -> instr_count = 0x0000; Reset pulse mid-RUN -> cpu_en low within the same cycle.
